// File: rtl/pong_pixel_gen.sv
// pong_pixel_gen: game state (ball, paddle, miss counter) updated once per
// frame in vertical blank, plus a one-cycle-latency pixel renderer that
// drives the vga block's single-bit colour inputs.
// Optional build macro: PONG_CENTER_NET_EN adds a dashed blue centre net.
module pong_pixel_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_X     = 16,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       oR,
  output logic       oG,
  output logic       oB,
  output logic [3:0] misses,
  output logic       frame_tick
);

  localparam int SC_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES + 1) : 1;

  localparam logic [9:0] BALL_X0      = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0      = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_Y0    = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] PADDLE_Y_MAX = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] PADDLE_STEP  = 10'(PADDLE_SPEED);
  localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_FRAMES - 1);

  // Signed limits for the 11-bit candidate-position arithmetic
  localparam logic signed [10:0] BALL_X_MAX_S = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] BALL_Y_MAX_S = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] HIT_X_S      = 11'(PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] STEP_S       = 11'(BALL_SPEED);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [9:0]      ball_x_reg, ball_x_next;
  logic [9:0]      ball_y_reg, ball_y_next;
  logic            dx_reg, dx_next;   // 1 = moving right (+x)
  logic            dy_reg, dy_next;   // 1 = moving down (+y)
  logic [9:0]      paddle_y_reg, paddle_y_next;
  logic [3:0]      misses_reg, misses_next;
  logic [SC_W-1:0] serve_cnt_reg, serve_cnt_next;
  logic            frame_tick_reg;

  logic signed [10:0] nx, ny;
  logic               rows_overlap;
  logic               paddle_hit;

  // Candidate next ball position and paddle/ball row overlap, used in PLAY
  always_comb begin
    nx = $signed({1'b0, ball_x_reg}) + (dx_reg ? STEP_S : -STEP_S);
    ny = $signed({1'b0, ball_y_reg}) + (dy_reg ? STEP_S : -STEP_S);
    rows_overlap = ({1'b0, ball_y_reg} <= ({1'b0, paddle_y_reg} + 11'(PADDLE_H - 1))) &&
                   (({1'b0, ball_y_reg} + 11'(BALL_SIZE - 1)) >= {1'b0, paddle_y_reg});
    paddle_hit = !dx_reg && (nx <= HIT_X_S) && rows_overlap;
  end

  // Next-state logic for paddle, ball and serve/play/miss sequencing
  always_comb begin
    state_next     = state_reg;
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    dx_next        = dx_reg;
    dy_next        = dy_reg;
    paddle_y_next  = paddle_y_reg;
    misses_next    = misses_reg;
    serve_cnt_next = serve_cnt_reg;

    // Paddle responds to exactly one button; both or neither holds it still
    if (btn_up && !btn_down) begin
      paddle_y_next = (paddle_y_reg < PADDLE_STEP) ? 10'd0 : (paddle_y_reg - PADDLE_STEP);
    end else if (btn_down && !btn_up) begin
      paddle_y_next = (paddle_y_reg > (PADDLE_Y_MAX - PADDLE_STEP)) ?
                      PADDLE_Y_MAX : (paddle_y_reg + PADDLE_STEP);
    end

    case (state_reg)
      SERVE: begin
        ball_x_next = BALL_X0;
        ball_y_next = BALL_Y0;
        if (serve_cnt_reg == SERVE_LAST) begin
          serve_cnt_next = '0;
          state_next     = PLAY;
          dx_next        = 1'b1;
        end else begin
          serve_cnt_next = serve_cnt_reg + 1'b1;
        end
      end

      PLAY: begin
        // Vertical axis: bounce off top and bottom walls
        if (ny < 11'sd0) begin
          ball_y_next = 10'd0;
          dy_next     = 1'b1;
        end else if (ny > BALL_Y_MAX_S) begin
          ball_y_next = BALL_Y_MAX_S[9:0];
          dy_next     = 1'b0;
        end else begin
          ball_y_next = ny[9:0];
        end

        // Horizontal axis: right wall, paddle return, or miss off the left
        if (nx > BALL_X_MAX_S) begin
          ball_x_next = BALL_X_MAX_S[9:0];
          dx_next     = 1'b0;
        end else if (paddle_hit) begin
          ball_x_next = HIT_X_S[9:0];
          dx_next     = 1'b1;
        end else if (nx < 11'sd0) begin
          state_next  = MISS;
        end else begin
          ball_x_next = nx[9:0];
        end
      end

      MISS: begin
        misses_next    = misses_reg + 4'd1;
        ball_x_next    = BALL_X0;
        ball_y_next    = BALL_Y0;
        serve_cnt_next = '0;
        state_next     = SERVE;
      end

      default: begin
        state_next = SERVE;
      end
    endcase
  end

  // Game state register: reset wins, otherwise advance only on frame_tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SERVE;
      ball_x_reg    <= BALL_X0;
      ball_y_reg    <= BALL_Y0;
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b1;
      paddle_y_reg  <= PADDLE_Y0;
      misses_reg    <= 4'd0;
      serve_cnt_reg <= '0;
    end else if (frame_tick_reg) begin
      state_reg     <= state_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      paddle_y_reg  <= paddle_y_next;
      misses_reg    <= misses_next;
      serve_cnt_reg <= serve_cnt_next;
    end
  end

  // Per-frame strobe: first pixel of the first blanking line
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
    end
  end

  // Pixel classification against current game state
  logic       in_active;
  logic       ball_pix;
  logic       paddle_pix;
  logic       net_pix;
  logic [2:0] rgb_next;     // {R, G, B}
  logic [2:0] rgb_reg;

  // Decide the colour of the pixel at (hcount, vcount)
  always_comb begin
    in_active  = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    ball_pix   = ({1'b0, hcount} >= {1'b0, ball_x_reg}) &&
                 ({1'b0, hcount} <= ({1'b0, ball_x_reg} + 11'(BALL_SIZE - 1))) &&
                 ({1'b0, vcount} >= {1'b0, ball_y_reg}) &&
                 ({1'b0, vcount} <= ({1'b0, ball_y_reg} + 11'(BALL_SIZE - 1)));
    paddle_pix = ({1'b0, hcount} >= 11'(PADDLE_X)) &&
                 ({1'b0, hcount} <= 11'(PADDLE_X + PADDLE_W - 1)) &&
                 ({1'b0, vcount} >= {1'b0, paddle_y_reg}) &&
                 ({1'b0, vcount} <= ({1'b0, paddle_y_reg} + 11'(PADDLE_H - 1)));
`ifdef PONG_CENTER_NET_EN
    // Four columns straddling the centre, 8-line dashes
    net_pix    = (hcount >= 10'(H_ACTIVE / 2 - 2)) &&
                 (hcount <= 10'(H_ACTIVE / 2 + 1)) &&
                 !vcount[3];
`else
    net_pix    = 1'b0;
`endif
    rgb_next = 3'b000;
    if (in_active) begin
      if (ball_pix) begin
        rgb_next = 3'b111;
      end else if (paddle_pix) begin
        rgb_next = 3'b010;
      end else if (net_pix) begin
        rgb_next = 3'b001;
      end
    end
  end

  // One register per colour channel gives the single cycle of latency
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
      always_ff @(posedge clk) begin
        if (reset) begin
          rgb_reg[gi] <= 1'b0;
        end else begin
          rgb_reg[gi] <= rgb_next[gi];
        end
      end
    end
  endgenerate

  assign oR         = rgb_reg[2];
  assign oG         = rgb_reg[1];
  assign oB         = rgb_reg[0];
  assign misses     = misses_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Directed bench for pong_pixel_gen. Frames are emulated by pulsing the
// vblank trigger coordinate rather than scanning full frames.
module tb_pong_pixel_gen;

  localparam int SERVE_ST = 0;
  localparam int PLAY_ST  = 1;
  localparam int MISS_ST  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       btn_up;
  logic       btn_down;
  logic       oR, oG, oB;
  logic [3:0] misses;
  logic       frame_tick;

  int vectors    = 0;
  int miscompares = 0;

  pong_pixel_gen #(.SERVE_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .oR         (oR),
    .oG         (oG),
    .oB         (oB),
    .misses     (misses),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame update: trigger coordinate for one cycle, strobe for one cycle
  task automatic do_tick();
    @(negedge clk); vcount = 10'd480; hcount = 10'd0;
    @(negedge clk); hcount = 10'd1;
    check("frame_tick_high", frame_tick, 1);
    @(negedge clk); vcount = 10'd0; hcount = 10'd700;
    check("frame_tick_low", frame_tick, 0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // Present a coordinate, then check the colour one clock later
  task automatic pix(input string tag, input int h, input int v, input logic [2:0] exp);
    @(negedge clk); hcount = 10'(h); vcount = 10'(v);
    @(negedge clk); hcount = 10'd700; vcount = 10'd0;
    check(tag, {oR, oG, oB}, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, "_x"}, dut.ball_x_reg, x);
    check({tag, "_y"}, dut.ball_y_reg, y);
  endtask

  initial begin
    reset = 1'b1; hcount = 10'd700; vcount = 10'd0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    check("rst_rgb", {oR, oG, oB}, 0);
    check("rst_misses", misses, 0);
    check("rst_frame_tick", frame_tick, 0);
    check_ball("rst_ball", 316, 236);
    check("rst_dx", dut.dx_reg, 1);
    check("rst_dy", dut.dy_reg, 1);
    check("rst_paddle", dut.paddle_y_reg, 208);
    check("rst_state", dut.state_reg, SERVE_ST);
    check("rst_serve_cnt", dut.serve_cnt_reg, 0);

    // Rendering at reset positions
    pix("ball_tl", 316, 236, 3'b111);
    pix("ball_br", 323, 243, 3'b111);
    pix("ball_left_out", 315, 236, 3'b000);
    pix("ball_right_out", 324, 243, 3'b000);
    pix("ball_below_out", 320, 244, 3'b000);
    pix("paddle_tl", 16, 208, 3'b010);
    pix("paddle_br", 23, 271, 3'b010);
    pix("paddle_right_out", 24, 271, 3'b000);
    pix("paddle_below_out", 16, 272, 3'b000);
    pix("paddle_above_out", 16, 207, 3'b000);
    pix("background", 100, 100, 3'b000);
    pix("hblank", 640, 236, 3'b000);
    pix("vblank", 316, 480, 3'b000);

    // Paddle motion and clamping
    btn_up = 1'b1;
    tick_n(51);
    check("paddle_up51", dut.paddle_y_reg, 4);
    tick_n(1);
    check("paddle_up52", dut.paddle_y_reg, 0);
    tick_n(8);
    check("paddle_up_clamp", dut.paddle_y_reg, 0);
    btn_down = 1'b1;
    tick_n(5);
    check("paddle_both", dut.paddle_y_reg, 0);
    btn_up = 1'b0;
    tick_n(104);
    check("paddle_down104", dut.paddle_y_reg, 416);
    tick_n(3);
    check("paddle_down_clamp", dut.paddle_y_reg, 416);
    btn_down = 1'b0;
    tick_n(2);
    check("paddle_none", dut.paddle_y_reg, 416);

    // Serve then flight: bottom wall, right wall, top wall, paddle return
    do_reset();
    tick_n(1);
    check("serve1_state", dut.state_reg, SERVE_ST);
    check("serve1_cnt", dut.serve_cnt_reg, 1);
    check_ball("serve1", 316, 236);
    tick_n(1);
    check("serve2_state", dut.state_reg, PLAY_ST);
    check("serve2_cnt", dut.serve_cnt_reg, 0);
    check_ball("serve2", 316, 236);
    tick_n(1);
    check_ball("play1", 318, 238);
    pix("ball_moved_tl", 318, 238, 3'b111);
    pix("ball_moved_old", 317, 238, 3'b000);
    tick_n(117);
    check_ball("reach_bottom", 552, 472);
    check("reach_bottom_dy", dut.dy_reg, 1);
    tick_n(1);
    check_ball("bounce_bottom", 554, 472);
    check("bounce_bottom_dy", dut.dy_reg, 0);
    tick_n(40);
    check_ball("bounce_right", 632, 392);
    check("bounce_right_dx", dut.dx_reg, 0);
    tick_n(197);
    check_ball("bounce_top", 238, 0);
    check("bounce_top_dy", dut.dy_reg, 1);
    tick_n(107);
    check_ball("paddle_hit", 24, 214);
    check("paddle_hit_dx", dut.dx_reg, 1);
    check("paddle_hit_state", dut.state_reg, PLAY_ST);
    check("paddle_hit_misses", misses, 0);

    // Same flight with the paddle parked at the top: ball is missed
    do_reset();
    btn_up = 1'b1;
    tick_n(52);
    btn_up = 1'b0;
    check("park_paddle", dut.paddle_y_reg, 0);
    pix("parked_paddle_top", 16, 0, 3'b010);
    pix("parked_paddle_below", 16, 64, 3'b000);
    tick_n(426);
    check("miss_state", dut.state_reg, MISS_ST);
    check_ball("miss_detect", 0, 240);
    check("miss_detect_misses", misses, 0);
    tick_n(1);
    check("miss1_count", misses, 1);
    check("miss1_state", dut.state_reg, SERVE_ST);
    check_ball("miss1_centre", 316, 236);
    check("miss1_dy_kept", dut.dy_reg, 1);
    for (int m = 2; m <= 16; m++) begin
      tick_n(479);
      check("miss_count", misses, 32'(m % 16));
    end
    check("miss_wrap_state", dut.state_reg, SERVE_ST);

    // Reset asserted on the strobe cycle mid-play wins over the update
    tick_n(10);
    check("pre_reset_state", dut.state_reg, PLAY_ST);
    check_ball("pre_reset", 332, 252);
    @(negedge clk); vcount = 10'd480; hcount = 10'd0;
    @(negedge clk); hcount = 10'd1; reset = 1'b1;
    check("pre_reset_tick", frame_tick, 1);
    @(negedge clk); reset = 1'b0; vcount = 10'd0; hcount = 10'd700;
    check("midreset_frame_tick", frame_tick, 0);
    check_ball("midreset_ball", 316, 236);
    check("midreset_dx", dut.dx_reg, 1);
    check("midreset_dy", dut.dy_reg, 1);
    check("midreset_paddle", dut.paddle_y_reg, 208);
    check("midreset_misses", misses, 0);
    check("midreset_state", dut.state_reg, SERVE_ST);
    check("midreset_serve_cnt", dut.serve_cnt_reg, 0);
    repeat (4) @(negedge clk);
    check_ball("midreset_hold", 316, 236);
    check("midreset_rgb", {oR, oG, oB}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pong_pixel_gen.md
Name: pong_pixel_gen

Overview:
- Game-logic and pixel-generation stage for the pong display.
- Sits directly upstream of the vga timing block: consumes its hcount/vcount and drives its single-bit iR/iG/iB colour inputs.
- Holds ball, player paddle and miss-counter state, updated once per frame during vertical blank.
- Renders ball and paddle into the pixel stream with one clock of latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BALL_SIZE, 8, ball edge length in pixels
- PADDLE_X, 16, left edge column of paddle
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- BALL_SPEED, 2, ball step per frame on each axis
- PADDLE_SPEED, 4, paddle step per frame
- SERVE_FRAMES, 60, frames ball is held at centre before play

Ports:
- clk  in  1  pixel clock, same clock as vga block
- reset  in  1  synchronous, active-high
- hcount  in  10  current column from vga block
- vcount  in  10  current line from vga block
- btn_up  in  1  level, move paddle up; already synchronised
- btn_down  in  1  level, move paddle down; already synchronised
- oR  out  1  red to vga iR
- oG  out  1  green to vga iG
- oB  out  1  blue to vga iB
- misses  out  4  missed-ball count
- frame_tick  out  1  one-cycle per-frame update strobe

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: all state loads on the clk edge while reset=1.
- Reset values:
  - ball_x=(H_ACTIVE-BALL_SIZE)/2=316, ball_y=(V_ACTIVE-BALL_SIZE)/2=236
  - dx=+1, dy=+1
  - paddle_y=(V_ACTIVE-PADDLE_H)/2=208
  - misses=0, state=SERVE, serve_cnt=0
  - oR/oG/oB=0, frame_tick=0
- Reset mid-frame or mid-play restores all reset values immediately. No partial move completes.
- frame_tick:
  - Registered; equals 1 for exactly one cycle, the cycle after (vcount==V_ACTIVE && hcount==0).
  - All game state updates only on edges where frame_tick==1.
- Paddle, on each tick:
  - up only: paddle_y -= PADDLE_SPEED, clamped at 0.
  - down only: paddle_y += PADDLE_SPEED, clamped at V_ACTIVE-PADDLE_H (416).
  - both or neither: no change.
  - Paddle moves in every state.
- FSM states: SERVE, PLAY, MISS.
  - SERVE: ball held at centre. serve_cnt increments each tick. When serve_cnt==SERVE_FRAMES-1, clear serve_cnt, go to PLAY, set dx=+1, and keep dy unchanged.
  - PLAY, each tick: candidate nx=ball_x±BALL_SPEED, ny=ball_y±BALL_SPEED, evaluated in 11-bit signed arithmetic.
    - ny<0: ball_y=0, dy=+1.
    - ny>V_ACTIVE-BALL_SIZE: ball_y=472, dy=-1.
    - nx>H_ACTIVE-BALL_SIZE: ball_x=632, dx=-1.
    - Paddle hit: dx=-1, nx<=PADDLE_X+PADDLE_W, and ball rows [ball_y, ball_y+BALL_SIZE-1] overlap paddle rows [paddle_y, paddle_y+PADDLE_H-1]. Result: ball_x=PADDLE_X+PADDLE_W=24, dx=+1.
    - nx<0 with no hit: go to MISS, and ball_x is not updated.
    - Corner case, x and y limits hit on the same tick: both axes are resolved independently in that tick.
  - MISS, one tick:
    - misses += 1, wrapping 15→0.
    - Ball returns to centre; dy is kept.
    - Go to SERVE.
- Rendering:
  - Pixel test uses the current hcount/vcount against the current state.
  - Outputs are registered, giving 1-cycle latency from hcount/vcount to oR/oG/oB.
  - Outside the active area (hcount>=H_ACTIVE or vcount>=V_ACTIVE): all outputs 0.
  - Ball pixel (hcount in [ball_x, ball_x+7], vcount in [ball_y, ball_y+7]): R=G=B=1.
  - Else paddle pixel: G=1, R=B=0.
  - Else background: 000.
  - Ball has priority over paddle.

Optional Feature:
- Macro: PONG_CENTER_NET_EN.
- When defined: active-area pixels that are not ball or paddle, with hcount in [318,321] and vcount[3]==0, output B=1 (dashed net, 8-line dashes). Ball and paddle priority is unchanged.
- When undefined: no net logic is generated; background stays black.

Test Plan:
- Reset, then one frame: ball pixel (316..323, 236..243) outputs 111 one cycle after hcount/vcount match. Paddle at rows 208..271, cols 16..23 outputs 010. misses=0.
- Hold btn_up 60 frames: paddle_y 208→0 after 52 ticks, then stays at 0. Holding both buttons leaves paddle_y unchanged.
- SERVE_FRAMES=2, BALL_SPEED=2: ball stays at (316,236) for 2 ticks, then moves to (318,238). After reaching y=472 it reverses to dy=-1 with ball_y=472 exactly.
- Ball travelling left with paddle_y aligned to ball_y: at nx<=24, ball_x=24 and dx=+1. misses unchanged.
- Paddle parked at 0, ball approaching at ball_y=400: MISS occurs, misses increments to 1, ball recentres. Forcing 16 misses returns misses to 0.
- Assert reset for 1 cycle mid-PLAY with ball at (100,50): next cycle all state equals reset values and frame_tick=0.
